// File: rtl/vecid_pkg.sv
// Shared types and width helpers for the vector-ID boundary stream.
package vecid_pkg;

  localparam int VECID_DEF_IDW = 3;

  typedef logic [VECID_DEF_IDW-1:0] vec_id_t;

  function automatic int seg_cnt_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/vecid_eq.sv
// N-bit equality: a + ~b + 1 reduced carry-save, summed by a Kogge-Stone
// prefix adder, and the difference zero-detected.
module vecid_eq #(
  parameter int N = 3
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq
);

  logic [N-1:0] cs_sum, cs_cry, g, p, g_nxt, p_nxt, diff;

  // NOTE: blocking assignments are correct here; this is combinational
  // scratch logic, with each level reading the previous level's values.
  always_comb begin
    cs_sum = a ^ ~b ^ N'(1);
    cs_cry = ((a & ~b) | (a & N'(1)) | (~b & N'(1))) << 1;
    g = cs_sum & cs_cry;
    p = cs_sum ^ cs_cry;
    for (int d = 1; d < N; d = d * 2) begin
      g_nxt = g;
      p_nxt = p;
      for (int i = d; i < N; i++) begin
        g_nxt[i] = g[i] | (p[i] & g[i-d]);
        p_nxt[i] = p[i] & p[i-d];
      end
      g = g_nxt;
      p = p_nxt;
    end
    diff = cs_sum ^ cs_cry ^ (g << 1);
    eq   = ~|diff;
  end

endmodule

// File: rtl/vecid_boundary_stream.sv
// Streaming multi-lane vector-ID boundary detector with registered valid/ready
// output. Define VECID_SEGCNT_EN to add the per-beat segment-start count.
module vecid_boundary_stream
  import vecid_pkg::*;
#(
  parameter int LANES = 8,
  parameter int IDW   = VECID_DEF_IDW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*IDW-1:0]         in_id,
  input  logic [LANES-1:0]             in_lmask,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0]             out_eq,
  output logic [LANES-1:0]             out_lmask,
`ifdef VECID_SEGCNT_EN
  output logic                         out_last,
  output logic [seg_cnt_w(LANES)-1:0]  out_seg_cnt
`else
  output logic                         out_last
`endif
);

  logic [IDW-1:0]   id [LANES];
  logic [LANES-1:0] eq_raw, lane_eq;
  logic             accept, fire;

  logic             out_valid_d, out_valid_q;
  logic [LANES-1:0] out_eq_d, out_eq_q;
  logic [LANES-1:0] out_lmask_d, out_lmask_q;
  logic             out_last_d, out_last_q;
  logic [IDW-1:0]   prev_id_d, prev_id_q;
  logic             prev_vld_d, prev_vld_q;

  // Lane 0 compares against the tail of the previous beat; others intra-beat.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign id[i] = in_id[i*IDW +: IDW];
    if (i == 0) begin : g_head
      vecid_eq #(.N(IDW)) u_eq (.a(id[0]), .b(prev_id_q), .eq(eq_raw[0]));
    end else begin : g_body
      vecid_eq #(.N(IDW)) u_eq (.a(id[i]), .b(id[i-1]), .eq(eq_raw[i]));
    end
  end

  assign lane_eq  = eq_raw & in_lmask & {in_lmask[LANES-2:0], prev_vld_q};
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign fire     = out_valid_q & out_ready;

  // NOTE: every variable gets its hold value first so no path infers a latch.
  always_comb begin
    out_valid_d = out_valid_q;
    out_eq_d    = out_eq_q;
    out_lmask_d = out_lmask_q;
    out_last_d  = out_last_q;
    prev_id_d   = prev_id_q;
    prev_vld_d  = prev_vld_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_eq_d    = lane_eq;
      out_lmask_d = in_lmask;
      out_last_d  = in_last;
      if (in_last) begin
        prev_vld_d = 1'b0;
      end else if (in_lmask[LANES-1]) begin
        prev_id_d  = id[LANES-1];
        prev_vld_d = 1'b1;
      end else begin
        prev_vld_d = 1'b0;
      end
    end else if (fire) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_eq_q    <= '0;
      out_lmask_q <= '0;
      out_last_q  <= 1'b0;
      prev_id_q   <= '0;
      prev_vld_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_eq_q    <= out_eq_d;
      out_lmask_q <= out_lmask_d;
      out_last_q  <= out_last_d;
      prev_id_q   <= prev_id_d;
      prev_vld_q  <= prev_vld_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_eq    = out_eq_q;
  assign out_lmask = out_lmask_q;
  assign out_last  = out_last_q;

`ifdef VECID_SEGCNT_EN
  localparam int SCW = seg_cnt_w(LANES);

  logic [LANES-1:0] seg_start;
  logic [SCW-1:0]   seg_cnt_d, seg_cnt_q;

  // Valid lanes that do not continue their predecessor start a new vector.
  assign seg_start = in_lmask & ~lane_eq;

  always_comb begin
    seg_cnt_d = seg_cnt_q;
    if (accept) begin
      seg_cnt_d = '0;
      for (int i = 0; i < LANES; i++) begin
        seg_cnt_d = seg_cnt_d + SCW'(seg_start[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_cnt_q <= '0;
    end else begin
      seg_cnt_q <= seg_cnt_d;
    end
  end

  assign out_seg_cnt = seg_cnt_q;
`endif

endmodule
